// File: rtl/mxint8_block_serializer_pkg.sv
// mxint8_block_serializer_pkg: MX block geometry, element/scale types and FSM states.
package mxint8_block_serializer_pkg;
  localparam int MX_BLOCK_SIZE = 32;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int MX_SCALE_WIDTH = 8;
  localparam logic [MX_SCALE_WIDTH-1:0] MX_SCALE_NAN = 8'hFF;
  typedef logic signed [MXINT8_ELEMENT_WIDTH-1:0] mxint8_elem_t;
  typedef mxint8_elem_t [0:MX_BLOCK_SIZE-1] mxint8_block_t;
  typedef logic [MX_SCALE_WIDTH-1:0] e8m0_t;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mxint8_block_serializer_if.sv
// mxint8_block_serializer_if: block-parallel input and element-serial output handshakes.
interface mxint8_block_serializer_if
  import mxint8_block_serializer_pkg::*;
#(
  parameter int BLOCK_SIZE = MX_BLOCK_SIZE,
  parameter int W = MXINT8_ELEMENT_WIDTH,
  parameter int SW = MX_SCALE_WIDTH
);
  localparam int IW = idx_width(BLOCK_SIZE);
  logic i_valid;
  logic i_ready;
  logic [SW-1:0] i_scale;
  logic [0:BLOCK_SIZE-1][W-1:0] i_mxint8_elements;
  logic o_valid;
  logic o_ready;
  logic [W-1:0] o_element;
  logic [SW-1:0] o_scale;
  logic [IW-1:0] o_index;
  logic o_first;
  logic o_last;
  logic o_scale_nan;
  modport slave (
    input i_valid, i_scale, i_mxint8_elements, o_ready,
    output i_ready, o_valid, o_element, o_scale, o_index, o_first, o_last, o_scale_nan
  );
  modport master (
    output i_valid, i_scale, i_mxint8_elements, o_ready,
    input i_ready, o_valid, o_element, o_scale, o_index, o_first, o_last, o_scale_nan
  );
endinterface

// File: rtl/mxint8_block_serializer.sv
// mxint8_block_serializer: captures one MXINT8 block and streams its elements one per cycle.
module mxint8_block_serializer
  import mxint8_block_serializer_pkg::*;
#(
  parameter int BLOCK_SIZE = MX_BLOCK_SIZE,
  parameter int W = MXINT8_ELEMENT_WIDTH,
  parameter int SW = MX_SCALE_WIDTH
) (
  input logic clk,
  input logic rst,
  mxint8_block_serializer_if.slave bus
);
  localparam int IW = idx_width(BLOCK_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);
  state_t r_state;
  state_t w_state_nx;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nx;
  logic [0:BLOCK_SIZE-1][W-1:0] r_hold;
  logic [SW-1:0] r_scale;
  logic w_last;
  logic w_fire;
  logic w_accept;
  assign w_last = r_idx == LAST_IDX;
  assign bus.o_valid = r_state == STREAM;
  assign w_fire = bus.o_valid && bus.o_ready;
  // a new block may slip in on the final beat so back-to-back blocks leave no bubble
  assign bus.i_ready = (r_state == IDLE) || (w_fire && w_last);
  assign w_accept = bus.i_valid && bus.i_ready;
  always_comb begin
    w_state_nx = w_accept ? STREAM : (w_fire && w_last) ? IDLE : r_state;
    w_idx_nx = (w_accept || (w_fire && w_last)) ? '0 : w_fire ? r_idx + IW'(1) : r_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_hold <= '0;
      r_scale <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx <= w_idx_nx;
      if (w_accept) begin
        r_hold <= bus.i_mxint8_elements;
        r_scale <= bus.i_scale;
      end
    end
  end
  assign bus.o_element = r_hold[r_idx];
  assign bus.o_scale = r_scale;
  assign bus.o_index = r_idx;
  assign bus.o_first = r_idx == '0;
  assign bus.o_last = w_last;
  assign bus.o_scale_nan = r_scale == SW'(MX_SCALE_NAN);
endmodule
